clip_distortion_pipe: RTL and testbench
=======================================

// Module: clip_distortion_pipe
// PURPOSE
//  Multichannel drive + clipping distortion stage for the pedalboard audio path.
//  - Applies gain, then clips each two's-complement sample symmetrically to +/-threshold.
//  - 3-stage pipeline with valid/ready handshake on both sides.
//  - Run-time threshold/drive config and a clip-event counter.
//  - Sits between the audio codec input FIFO and downstream effects / codec output.
// PARAMETERS
//  DATA_W      32             sample width per channel, two's complement
//  CH          2              channel count; channel c = in_data[c*DATA_W +: DATA_W]
//  GAIN_W      8              drive width, unsigned fixed point
//  GAIN_FRAC   4              fractional bits of drive (1.0 = 1<<GAIN_FRAC)
//  THR_DEFAULT 1_000_000_000  reset threshold, unsigned, <= 2^(DATA_W-1)-1
// PORTS
//  CLOCK_50       in   1          system clock, all logic rising-edge
//  resetn         in   1          asynchronous active-low reset
//  enable         in   1          1 = distort, 0 = bypass (sampled per sample)
//  in_valid       in   1          input sample set valid
//  in_ready       out  1          block accepts input this cycle
//  in_data        in   CH*DATA_W  packed input samples
//  out_valid      out  1          output sample set valid
//  out_ready      in   1          downstream accepts output
//  out_data       out  CH*DATA_W  packed output samples
//  cfg_load       in   1          pulse: capture cfg_threshold/cfg_drive into shadow regs
//  cfg_threshold  in   DATA_W-1   new clip threshold (unsigned magnitude)
//  cfg_drive      in   GAIN_W     new drive value
//  clip_clr       in   1          pulse: clear clip_cnt
//  clip_cnt       out  16         count of output sample sets with >=1 clipped channel
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, clip_cnt=0; all stage valids 0.
//    Active threshold=THR_DEFAULT; drive=1<<GAIN_FRAC. Shadow regs take the same values.
//  Handshake and stalls:
//  - adv = out_ready | ~out_valid; in_ready = adv; all stages move only when adv=1.
//  - Input accepted when in_valid & in_ready.
//  - While out_valid=1 & out_ready=0, out_data and out_valid hold stable.
//  - Latency: accepted input to out_valid = 3 cycles with no stall.
//  - Throughput: 1 sample set/cycle; bubbles (in_valid=0) propagate as invalid stages.
//  Config:
//  - cfg_load writes the shadow regs.
//  - Shadow copies into the active regs on the next accepted input; that input is the first to use them.
//  - Every sample in flight keeps the values it captured at acceptance.
//  - If cfg_load coincides with an acceptance, the accepted sample uses the old active values;
//    the new values apply from the following acceptance.
//  Mode: enable is captured with each accepted sample and travels with it through the pipe.
//    Toggling enable never alters in-flight samples.
//  S1 gain (enable=1):
//  - p = x * drive, full-precision signed product.
//  - Shift p right by GAIN_FRAC, arithmetic.
//  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  - Bypass: x passes unchanged.
//  S2 clip (enable=1):
//  - y = thr if g > thr; y = -thr if g < -thr; else y = g.
//  - thr is zero-extended; -thr is always representable.
//  - thr=0 gives output 0. Per-channel clip flag = clipping occurred.
//  - Bypass: no clipping, flags 0.
//  S3: registers out_data/out_valid and ORs the per-channel clip flags into clip_any.
//  clip_cnt:
//  - +1 on each output handshake (out_valid & out_ready) with clip_any=1.
//  - Saturates at 16'hFFFF.
//  - clip_clr has priority over a simultaneous increment; that increment is lost.
//  Reset mid-operation: in-flight samples are discarded with no output handshake;
//    config returns to defaults.
// CONFIGURATION
//  SOFT_CLIP_EN defined: S2 applies a knee at k = thr - (thr>>2) before the hard clip.
//  - |g| > k is replaced by sign(g)*(k + ((|g|-k)>>1)), then hard-clipped to +/-thr.
//  - Clip flag = knee region entered.
//  - Latency unchanged, 3 cycles.
//  SOFT_CLIP_EN undefined: pure hard clip as above; knee logic absent.
// TESTING
//  1. Defaults, enable=1, L=1_200_000_000, R=-1_200_000_000
//     -> out L=1_000_000_000, R=-1_000_000_000 after 3 cycles; clip_cnt=1.
//  2. enable=0, L=2_000_000_000 -> out L=2_000_000_000 unchanged, latency 3; clip_cnt unchanged.
//  3. drive=8'h20 (2.0), thr=100, L=40, R=60 -> out L=80, R=100; clip flag on R only; clip_cnt +1.
//  4. drive=8'hFF, L=2^30 -> gain saturates to 2^31-1 -> clipped to thr.
//     L=-2^31 -> -thr, never wraps positive.
//  5. Stream 8 sets; hold out_ready=0 for 5 cycles mid-stream
//     -> out_data stable, in_ready=0, no loss or duplicate; output order preserved.
//  6. cfg_load thr=500 while 3 samples in flight -> those 3 use old thr, next accepted uses 500.
//     clip_clr at clip_cnt=16'hFFFF with clipped handshake -> clip_cnt=0.

Source files
------------

// File: rtl/clip_distortion_pipe.sv
// Multichannel drive + clipping distortion stage: gain, symmetric clip, output register,
// valid/ready on both sides. Define SOFT_CLIP_EN to add a soft knee ahead of the hard clip.
module clip_distortion_pipe #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CH          = 2,
  parameter int unsigned GAIN_W      = 8,
  parameter int unsigned GAIN_FRAC   = 4,
  parameter int unsigned THR_DEFAULT = 1_000_000_000
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*DATA_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH*DATA_W-1:0]   out_data,
  input  logic                   cfg_load,
  input  logic [DATA_W-2:0]      cfg_threshold,
  input  logic [GAIN_W-1:0]      cfg_drive,
  input  logic                   clip_clr,
  output logic [15:0]            clip_cnt
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
  localparam int unsigned EXT_W  = DATA_W + 1;
  localparam logic [DATA_W-2:0] THR_RST = (DATA_W-1)'(THR_DEFAULT);
  localparam logic [GAIN_W-1:0] DRV_RST = GAIN_W'(1 << GAIN_FRAC);

  // Signed x * unsigned drive, arithmetic shift by GAIN_FRAC, saturate to DATA_W.
  function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] x,
                                                   input logic [GAIN_W-1:0] drv);
    logic signed [PROD_W-1:0] xs;
    logic signed [PROD_W-1:0] ds;
    logic signed [PROD_W-1:0] sh;
    logic [PROD_W-DATA_W:0]   top;
    xs  = {{(PROD_W-DATA_W){x[DATA_W-1]}}, x};
    ds  = {{(PROD_W-GAIN_W){1'b0}}, drv};
    sh  = (xs * ds) >>> GAIN_FRAC;
    top = sh[PROD_W-1:DATA_W-1];
    if (top == '0 || top == '1) begin
      return sh[DATA_W-1:0];
    end else if (sh[PROD_W-1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  // Returns {clip_flag, y}; thr is an unsigned magnitude, so +/-thr always fits in DATA_W.
  function automatic logic [DATA_W:0] apply_clip(input logic [DATA_W-1:0] g,
                                                 input logic [DATA_W-2:0] thr);
`ifdef SOFT_CLIP_EN
    logic [EXT_W-1:0] thr_x;
    logic [EXT_W-1:0] mag;
    logic [EXT_W-1:0] knee;
    logic [EXT_W-1:0] bent;
    logic [EXT_W-1:0] res;
    thr_x = {2'b00, thr};
    mag   = g[DATA_W-1] ? (~{1'b1, g} + 1'b1) : {1'b0, g};
    knee  = thr_x - (thr_x >> 2);
    if (mag > knee) begin
      bent = knee + ((mag - knee) >> 1);
      if (bent > thr_x) begin
        bent = thr_x;
      end
      res = g[DATA_W-1] ? (~bent + 1'b1) : bent;
      return {1'b1, res[DATA_W-1:0]};
    end
    return {1'b0, g};
`else
    logic signed [EXT_W-1:0] gx;
    logic signed [EXT_W-1:0] tx;
    logic signed [EXT_W-1:0] nt;
    gx = {g[DATA_W-1], g};
    tx = {2'b00, thr};
    nt = -tx;
    if (gx > tx) begin
      return {1'b1, tx[DATA_W-1:0]};
    end else if (gx < nt) begin
      return {1'b1, nt[DATA_W-1:0]};
    end
    return {1'b0, g};
`endif
  endfunction

  logic              adv;
  logic              accept;
  logic              pend;
  logic [DATA_W-2:0] thr_act;
  logic [DATA_W-2:0] thr_sh;
  logic [DATA_W-2:0] thr_use;
  logic [GAIN_W-1:0] drv_act;
  logic [GAIN_W-1:0] drv_sh;
  logic [GAIN_W-1:0] drv_use;

  logic [DATA_W-1:0] gain_c  [CH];
  logic [DATA_W-1:0] s1_data [CH];
  logic [DATA_W-2:0] s1_thr;
  logic              s1_en;
  logic              s1_valid;

  logic [DATA_W:0]   clip_res [CH];
  logic [DATA_W-1:0] clip_c   [CH];
  logic [CH-1:0]     flag_c;
  logic [DATA_W-1:0] s2_data  [CH];
  logic [CH-1:0]     s2_flag;
  logic              s2_valid;
  logic              clip_any;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  // A pending shadow load applies to the next accepted set; otherwise the active values do.
  assign thr_use = pend ? thr_sh : thr_act;
  assign drv_use = pend ? drv_sh : drv_act;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin : cfg_regs
    if (!resetn) begin
      thr_sh  <= THR_RST;
      drv_sh  <= DRV_RST;
      thr_act <= THR_RST;
      drv_act <= DRV_RST;
      pend    <= 1'b0;
    end else begin
      if (cfg_load) begin
        thr_sh <= cfg_threshold;
        drv_sh <= cfg_drive;
      end
      if (accept) begin
        thr_act <= thr_use;
        drv_act <= drv_use;
      end
      if (cfg_load) begin
        pend <= 1'b1;
      end else if (accept) begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin : gain_stage
    for (int c = 0; c < CH; c++) begin
      gain_c[c] = in_data[c*DATA_W +: DATA_W];
      if (enable) begin
        gain_c[c] = apply_gain(in_data[c*DATA_W +: DATA_W], drv_use);
      end
    end
  end

  always_comb begin : clip_stage
    flag_c = '0;
    for (int c = 0; c < CH; c++) begin
      clip_res[c] = apply_clip(s1_data[c], s1_thr);
      clip_c[c]   = s1_data[c];
      if (s1_en) begin
        clip_c[c] = clip_res[c][DATA_W-1:0];
        flag_c[c] = clip_res[c][DATA_W];
      end
    end
  end

  // Mode and threshold ride along with each set so in-flight data never sees later changes.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin : pipe
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_en     <= 1'b0;
      s1_thr    <= '0;
      s2_valid  <= 1'b0;
      s2_flag   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      clip_any  <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        s1_data[c] <= '0;
        s2_data[c] <= '0;
      end
    end else if (adv) begin
      s1_valid  <= accept;
      s1_en     <= enable;
      s1_thr    <= thr_use;
      s2_valid  <= s1_valid;
      s2_flag   <= s1_valid ? flag_c : '0;
      out_valid <= s2_valid;
      clip_any  <= s2_valid & (|s2_flag);
      for (int c = 0; c < CH; c++) begin
        s1_data[c]                    <= gain_c[c];
        s2_data[c]                    <= clip_c[c];
        out_data[c*DATA_W +: DATA_W]  <= s2_data[c];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin : clip_counter
    if (!resetn) begin
      clip_cnt <= '0;
    end else if (clip_clr) begin
      clip_cnt <= '0;
    end else if (out_valid && out_ready && clip_any && clip_cnt != 16'hFFFF) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_clip_distortion_pipe.sv
// Randomised scoreboard bench for clip_distortion_pipe (2 x 32-bit channels).
module tb_clip_distortion_pipe;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        cfg_load;
  logic [30:0] cfg_threshold;
  logic [7:0]  cfg_drive;
  logic        clip_clr;
  logic [15:0] clip_cnt;

  clip_distortion_pipe dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .enable        (enable),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .cfg_load      (cfg_load),
    .cfg_threshold (cfg_threshold),
    .cfg_drive     (cfg_drive),
    .clip_clr      (clip_clr),
    .clip_cnt      (clip_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [63:0] data;
    bit          clip;
  } exp_t;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  longint      m_thr = 1_000_000_000;
  longint      m_drv = 16;
  int          stall_cnt = 0;
  bit          rand_ready = 1'b0;
  int          model_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: plain integer arithmetic on the spec's rules.
  function automatic logic [32:0] ref_ch(logic [31:0] x, bit en);
    longint g;
    longint t;
    bit     flag;
`ifdef SOFT_CLIP_EN
    longint k;
    longint mag;
    longint m;
`endif
    flag = 1'b0;
    if (!en) return {1'b0, x};
    g = ($signed(x) * m_drv) >>> 4;
    if (g > MAXV) g = MAXV;
    if (g < MINV) g = MINV;
    t = m_thr;
`ifdef SOFT_CLIP_EN
    k   = t - t / 4;
    mag = (g < 0) ? -g : g;
    if (mag > k) begin
      m = k + (mag - k) / 2;
      if (m > t) m = t;
      g = (g < 0) ? -m : m;
      flag = 1'b1;
    end
`else
    if (g > t) begin
      g = t;
      flag = 1'b1;
    end else if (g < -t) begin
      g = -t;
      flag = 1'b1;
    end
`endif
    return {flag, 32'(g)};
  endfunction

  function automatic exp_t expect_set(logic [63:0] d, bit en);
    exp_t e;
    logic [32:0] r0;
    logic [32:0] r1;
    r0 = ref_ch(d[31:0], en);
    r1 = ref_ch(d[63:32], en);
    e.data = {r1[31:0], r0[31:0]};
    e.clip = r0[32] | r1[32];
    return e;
  endfunction

  function automatic logic [31:0] rnd_x();
    case ($urandom_range(0, 4))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 4000)) - 32'd2000;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return 32'($signed($urandom) >>> 8);
    endcase
  endfunction

  // One cycle of input drive, starting just after a rising edge.
  task automatic step(input bit v, input logic [63:0] d, input bit en, input bit ld,
                      input logic [30:0] thr, input logic [7:0] drv, input bit clr,
                      output bit acc);
    in_valid      = v;
    in_data       = d;
    enable        = en;
    cfg_load      = ld;
    cfg_threshold = thr;
    cfg_drive     = drv;
    clip_clr      = clr;
    @(negedge CLOCK_50);
    acc = v && in_ready && resetn;
    if (acc) sb.push_back(expect_set(d, en));
    if (ld) begin
      m_thr = longint'(thr);
      m_drv = longint'(drv);
    end
    @(posedge CLOCK_50);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    clip_clr = 1'b0;
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r, input bit en);
    bit acc;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, {r, l}, en, 1'b0, '0, '0, 1'b0, acc);
      if (acc) return;
    end
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic load(input logic [30:0] thr, input logic [7:0] drv);
    bit acc;
    step(1'b0, '0, 1'b1, 1'b1, thr, drv, 1'b0, acc);
  endtask

  always @(posedge CLOCK_50) begin
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: everything sampled at the falling edge, ahead of the handshake edge.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (!resetn) begin
      sb.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      check("clip_cnt", 64'(clip_cnt), 64'(model_cnt));
      check("in_ready", 64'(in_ready), 64'(out_ready || !out_valid));
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", out_data, 64'hDEAD_DEAD_DEAD_DEAD);
          e.clip = 1'b0;
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
        end
        if (clip_clr) model_cnt = 0;
        else if (e.clip && model_cnt != 65535) model_cnt++;
      end else if (clip_clr) begin
        model_cnt = 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    bit acc;
    int lat;
    bit v;
    bit en;
    bit ld;
    bit clr;
    logic [30:0] thr;
    resetn = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_load = 1'b0; cfg_threshold = '0; cfg_drive = '0; clip_clr = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_clip_cnt", 64'(clip_cnt), 64'd0);
    resetn = 1'b1;

    // Default config hard clip, with latency measured on an empty pipe
    send(32'd1_200_000_000, -32'd1_200_000_000, 1'b1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLOCK_50);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("latency", 64'(lat), 64'd3);
    @(posedge CLOCK_50);
    #1;

    send(32'd2_000_000_000, 32'd7, 1'b0);
    load(31'd100, 8'h20);
    send(32'd40, 32'd60, 1'b1);
    load(31'd100, 8'hFF);
    send(32'h4000_0000, 32'd3, 1'b1);
    send(32'h8000_0000, 32'd5, 1'b1);
    load(31'd0, 8'h10);
    send(32'd12345, -32'd9, 1'b1);

    // Stream 8 sets with a 5-cycle output stall in the middle
    load(31'd100_000, 8'h18);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) stall_cnt = 5;
      send(rnd_x(), rnd_x(), 1'b1);
    end

    // Load while 3 sets are in flight, then a load coinciding with an acceptance
    load(31'd100, 8'h10);
    repeat (3) send(32'd2000, -32'd2000, 1'b1);
    load(31'd500, 8'h10);
    send(32'd2000, -32'd2000, 1'b1);
    step(1'b1, {32'd900, 32'd800}, 1'b1, 1'b1, 31'd700, 8'h10, 1'b0, acc);
    send(32'd800, 32'd900, 1'b1);

    // Randomised traffic with backpressure, config changes and clears
    rand_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 4) != 0);
      ld  = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 3))
        0:       thr = '0;
        1:       thr = 31'($urandom_range(0, 5000));
        default: thr = 31'($urandom);
      endcase
      step(v, {rnd_x(), rnd_x()}, en, ld, thr, 8'($urandom), clr, acc);
    end
    rand_ready = 1'b0;

    // Reset with sets in flight: they vanish and config returns to defaults
    load(31'd50, 8'h40);
    repeat (2) send(32'd1000, 32'd1000, 1'b1);
    resetn = 1'b0;
    m_thr = 1_000_000_000;
    m_drv = 16;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_clip_cnt", 64'(clip_cnt), 64'd0);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    resetn = 1'b1;
    send(32'd1_200_000_000, 32'd10, 1'b1);

    // Drive clip_cnt into saturation, then clear on a clipped handshake
    load(31'd100, 8'h10);
    for (int i = 0; i < 65545; i++) begin
      step(1'b1, {32'd1000, -32'd5}, 1'b1, 1'b0, '0, '0, 1'b0, acc);
    end
    step(1'b1, {32'd1000, 32'd1000}, 1'b1, 1'b0, '0, '0, 1'b1, acc);
    repeat (4) send(32'd1000, 32'd1, 1'b1);

    for (int i = 0; i < 500; i++) begin
      @(negedge CLOCK_50);
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
